// File: rtl/hid_typer_pkg.sv
// Shared constants for the HID typer: modifier bits, FSM state codes,
// named key usages and the keymap lookup result type.
package hid_typer_pkg;

    // HID modifier byte bits
    localparam logic [7:0] MOD_LCTRL  = 8'h01;
    localparam logic [7:0] MOD_LSHIFT = 8'h02;
    localparam logic [7:0] MOD_RALT   = 8'h40;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRESS   = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    // Named HID usage codes; Enter is the keypad Enter used for line feed
    localparam logic [7:0] KEY_RETURN    = 8'h28;
    localparam logic [7:0] KEY_ESCAPE    = 8'h29;
    localparam logic [7:0] KEY_BACKSPACE = 8'h2A;
    localparam logic [7:0] KEY_TAB       = 8'h2B;
    localparam logic [7:0] KEY_DELETE    = 8'h4C;
    localparam logic [7:0] KEY_ENTER     = 8'h58;

    typedef struct packed {
        logic [7:0] mod;
        logic [7:0] key;
        logic       hit;
    } keymap_t;

endpackage

// File: rtl/ascii_keymap.sv
// Combinational ASCII to Spanish-layout HID lookup: {modifier, usage, hit}.
module ascii_keymap
    import hid_typer_pkg::*;
(
    input  logic [7:0] i_byte,
    output keymap_t    o_map
);

    // Letters and digits by offset, everything else by explicit table
    always_comb begin
        o_map     = '0;
        o_map.hit = 1'b1;
        if (i_byte >= 8'h61 && i_byte <= 8'h7A) begin
            o_map.key = i_byte - 8'h5D;
        end else if (i_byte >= 8'h41 && i_byte <= 8'h5A) begin
            o_map.mod = MOD_LSHIFT;
            o_map.key = i_byte - 8'h3D;
        end else if (i_byte >= 8'h31 && i_byte <= 8'h39) begin
            o_map.key = i_byte - 8'h13;
        end else begin
            case (i_byte)
                8'h30: o_map.key = 8'h27;
                // shifted digit row
                8'h21: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h1E; end
                8'h22: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h1F; end
                8'h24: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h21; end
                8'h25: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h22; end
                8'h26: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h23; end
                8'h2F: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h24; end
                8'h28: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h25; end
                8'h29: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h26; end
                8'h3D: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h27; end
                // AltGr symbols
                8'h7C: begin o_map.mod = MOD_RALT; o_map.key = 8'h1E; end
                8'h40: begin o_map.mod = MOD_RALT; o_map.key = 8'h1F; end
                8'h23: begin o_map.mod = MOD_RALT; o_map.key = 8'h20; end
                8'h7E: begin o_map.mod = MOD_RALT; o_map.key = 8'h21; end
                8'h5B: begin o_map.mod = MOD_RALT; o_map.key = 8'h2F; end
                8'h5D: begin o_map.mod = MOD_RALT; o_map.key = 8'h30; end
                8'h7D: begin o_map.mod = MOD_RALT; o_map.key = 8'h32; end
                8'h7B: begin o_map.mod = MOD_RALT; o_map.key = 8'h34; end
                8'h5C: begin o_map.mod = MOD_RALT; o_map.key = 8'h35; end
                // unshifted punctuation
                8'h27: o_map.key = 8'h2D;
                8'h60: o_map.key = 8'h2F;
                8'h2B: o_map.key = 8'h30;
                8'h2C: o_map.key = 8'h36;
                8'h2E: o_map.key = 8'h37;
                8'h2D: o_map.key = 8'h38;
                8'h3C: o_map.key = 8'h64;
                8'h20: o_map.key = 8'h2C;
                // shifted punctuation
                8'h3F: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h2D; end
                8'h5E: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h2F; end
                8'h2A: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h30; end
                8'h3B: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h36; end
                8'h3A: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h37; end
                8'h5F: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h38; end
                8'h3E: begin o_map.mod = MOD_LSHIFT; o_map.key = 8'h64; end
                // control keys that have their own usage
                8'h08: o_map.key = KEY_BACKSPACE;
                8'h09: o_map.key = KEY_TAB;
                8'h0A: o_map.key = KEY_ENTER;
                8'h0D: o_map.key = KEY_RETURN;
                8'h1B: o_map.key = KEY_ESCAPE;
                8'h7F: o_map.key = KEY_DELETE;
                default: begin
                    // remaining ^A..^Z become Ctrl+letter
                    if (i_byte >= 8'h01 && i_byte <= 8'h1A) begin
                        o_map.mod = MOD_LCTRL;
                        o_map.key = i_byte + 8'h03;
                    end else begin
                        o_map.hit = 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/hid_typer.sv
// Turns accepted ASCII characters into timed press/release HID reports.
module hid_typer
    import hid_typer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_mod,
    output logic [7:0] o_key,
    output logic       o_rep_valid,
    input  logic       i_rep_ready,
    output logic       o_err
);

    // GAP_LOAD is only used when GAP_CYCLES is non-zero
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  mod_q, mod_d;
    logic [7:0]  key_q, key_d;
    logic        err_q, err_d;
    keymap_t     key_map;

    ascii_keymap u_keymap (
        .i_byte (i_byte),
        .o_map  (key_map)
    );

    // Next-state, counter and report register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        key_d   = key_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (key_map.hit) begin
                        state_d = ST_PRESS;
                        mod_d   = key_map.mod;
                        key_d   = key_map.key;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (i_rep_ready) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    // clearing here makes the release report all-zero
                    mod_d   = 8'h00;
                    key_d   = 8'h00;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RELEASE: begin
                if (i_rep_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            mod_q   <= 8'h00;
            key_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        o_ready     = (state_q == ST_IDLE);
        o_rep_valid = (state_q == ST_PRESS) || (state_q == ST_RELEASE);
        o_mod       = mod_q;
        o_key       = key_q;
        o_err       = err_q;
    end

endmodule

// File: tb/tb_hid_typer.sv
// Self-checking bench for hid_typer with a behavioural keymap and timing model.
module tb_hid_typer;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_byte = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] o_mod;
    logic [7:0] o_key;
    logic       o_rep_valid;
    logic       i_rep_ready = 1'b0;
    logic       o_err;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int acc_cyc = 0;

    hid_typer #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_byte      (i_byte),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_mod       (o_mod),
        .o_key       (o_key),
        .o_rep_valid (o_rep_valid),
        .i_rep_ready (i_rep_ready),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Spanish layout table written straight from the character lists
    function automatic void ref_map(input logic [7:0] c, output logic [7:0] m,
                                    output logic [7:0] k, output logic h);
        m = 8'h00;
        k = 8'h00;
        h = 1'b1;
        if (c >= "a" && c <= "z") begin
            k = 8'h04 + (c - "a");
        end else if (c >= "A" && c <= "Z") begin
            m = 8'h02;
            k = 8'h04 + (c - "A");
        end else if (c >= "1" && c <= "9") begin
            k = 8'h1E + (c - "1");
        end else begin
            case (c)
                "0":  k = 8'h27;
                "!":  begin m = 8'h02; k = 8'h1E; end
                "\"": begin m = 8'h02; k = 8'h1F; end
                "$":  begin m = 8'h02; k = 8'h21; end
                "%":  begin m = 8'h02; k = 8'h22; end
                "&":  begin m = 8'h02; k = 8'h23; end
                "/":  begin m = 8'h02; k = 8'h24; end
                "(":  begin m = 8'h02; k = 8'h25; end
                ")":  begin m = 8'h02; k = 8'h26; end
                "=":  begin m = 8'h02; k = 8'h27; end
                "|":  begin m = 8'h40; k = 8'h1E; end
                "@":  begin m = 8'h40; k = 8'h1F; end
                "#":  begin m = 8'h40; k = 8'h20; end
                "~":  begin m = 8'h40; k = 8'h21; end
                "[":  begin m = 8'h40; k = 8'h2F; end
                "]":  begin m = 8'h40; k = 8'h30; end
                "}":  begin m = 8'h40; k = 8'h32; end
                "{":  begin m = 8'h40; k = 8'h34; end
                "\\": begin m = 8'h40; k = 8'h35; end
                "'":  k = 8'h2D;
                8'h60: k = 8'h2F;
                "+":  k = 8'h30;
                ",":  k = 8'h36;
                ".":  k = 8'h37;
                "-":  k = 8'h38;
                "<":  k = 8'h64;
                " ":  k = 8'h2C;
                "?":  begin m = 8'h02; k = 8'h2D; end
                "^":  begin m = 8'h02; k = 8'h2F; end
                "*":  begin m = 8'h02; k = 8'h30; end
                ";":  begin m = 8'h02; k = 8'h36; end
                ":":  begin m = 8'h02; k = 8'h37; end
                "_":  begin m = 8'h02; k = 8'h38; end
                ">":  begin m = 8'h02; k = 8'h64; end
                8'h08: k = 8'h2A;
                8'h09: k = 8'h2B;
                8'h0A: k = 8'h58;
                8'h0D: k = 8'h28;
                8'h1B: k = 8'h29;
                8'h7F: k = 8'h4C;
                default: begin
                    if (c >= 8'h01 && c <= 8'h1A) begin
                        m = 8'h01;
                        k = c + 8'h03;
                    end else begin
                        h = 1'b0;
                    end
                end
            endcase
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic send_char(input logic [7:0] c, input int stall_p, input int stall_r);
        logic [7:0] em, ek;
        logic       eh;
        int         n;
        ref_map(c, em, ek, eh);
        vec++;
        if (o_ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_before_accept char=%h: got %b want 1", c, o_ready);
        end
        i_byte  = c;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_byte  = 8'($urandom);
        acc_cyc = cyc;
        if (!eh) begin
            vec++;
            if ({o_err, o_rep_valid, o_ready} !== 3'b101) begin
                errs++;
                $display("FAIL unmapped char=%h: got err/valid/ready=%b want 101", c,
                         {o_err, o_rep_valid, o_ready});
            end
            return;
        end
        vec++;
        if ({o_rep_valid, o_mod, o_key, o_err, o_ready} !== {1'b1, em, ek, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL press char=%h: got v=%b mod=%h key=%h err=%b rdy=%b want 1 %h %h 0 0",
                     c, o_rep_valid, o_mod, o_key, o_err, o_ready, em, ek);
        end
        for (int s = 0; s < stall_p; s++) begin
            i_rep_ready = 1'b0;
            @(negedge i_clk);
            vec++;
            if ({o_rep_valid, o_mod, o_key} !== {1'b1, em, ek}) begin
                errs++;
                $display("FAIL press_stall char=%h cyc=%0d: got v=%b mod=%h key=%h want 1 %h %h",
                         c, s, o_rep_valid, o_mod, o_key, em, ek);
            end
        end
        i_rep_ready = 1'b1;
        @(negedge i_clk);
        i_rep_ready = 1'($urandom);
        n = 0;
        while (o_rep_valid === 1'b0 && n < 200) begin
            vec++;
            if ({o_mod, o_key, o_ready} !== 17'h0) begin
                errs++;
                $display("FAIL hold_idle_out char=%h: got mod=%h key=%h rdy=%b want 0 0 0",
                         c, o_mod, o_key, o_ready);
            end
            n++;
            @(negedge i_clk);
            i_rep_ready = 1'($urandom);
        end
        vec++;
        if (n != HOLD) begin
            errs++;
            $display("FAIL hold_len char=%h: got %0d want %0d", c, n, HOLD);
        end
        vec++;
        if ({o_rep_valid, o_mod, o_key} !== {1'b1, 16'h0000}) begin
            errs++;
            $display("FAIL release char=%h: got v=%b mod=%h key=%h want 1 00 00",
                     c, o_rep_valid, o_mod, o_key);
        end
        for (int s = 0; s < stall_r; s++) begin
            i_rep_ready = 1'b0;
            @(negedge i_clk);
            vec++;
            if ({o_rep_valid, o_mod, o_key} !== {1'b1, 16'h0000}) begin
                errs++;
                $display("FAIL release_stall char=%h: got v=%b mod=%h key=%h want 1 00 00",
                         c, o_rep_valid, o_mod, o_key);
            end
        end
        i_rep_ready = 1'b1;
        @(negedge i_clk);
        i_rep_ready = 1'($urandom);
        n = 0;
        while (o_ready === 1'b0 && n < 200) begin
            vec++;
            if (o_rep_valid !== 1'b0) begin
                errs++;
                $display("FAIL gap_valid char=%h: got %b want 0", c, o_rep_valid);
            end
            n++;
            @(negedge i_clk);
            i_rep_ready = 1'($urandom);
        end
        vec++;
        if (n != GAP) begin
            errs++;
            $display("FAIL gap_len char=%h: got %0d want %0d", c, n, GAP);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_valid = 1'b1;
        i_byte = "x";
        repeat (3) @(negedge i_clk);
        vec++;
        if ({o_ready, o_rep_valid, o_mod, o_key, o_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: got rdy=%b v=%b mod=%h key=%h err=%b want 1 0 00 00 0",
                     o_ready, o_rep_valid, o_mod, o_key, o_err);
        end
        i_valid = 1'b0;
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_timing();
        int t0;
        i_rep_ready = 1'b1;
        send_char("a", 0, 0);
        t0 = acc_cyc;
        send_char("b", 0, 0);
        vec++;
        if (acc_cyc - t0 != 3 + HOLD + GAP) begin
            errs++;
            $display("FAIL accept_spacing: got %0d want %0d", acc_cyc - t0, 3 + HOLD + GAP);
        end
    endtask

    task automatic test_modifiers();
        send_char("A", 0, 0);
        send_char("@", 1, 0);
        send_char(8'h03, 0, 2);
        send_char(8'h0A, 0, 0);
        send_char("\\", 0, 0);
    endtask

    task automatic test_back_to_back();
        send_char("l", 0, 0);
        send_char("l", 0, 0);
    endtask

    task automatic test_unmapped();
        int t0;
        send_char(8'h00, 0, 0);
        t0 = acc_cyc;
        send_char(8'h80, 0, 0);
        vec++;
        if (acc_cyc - t0 != 1) begin
            errs++;
            $display("FAIL unmapped_b2b: got spacing %0d want 1", acc_cyc - t0);
        end
        @(negedge i_clk);
        vec++;
        if ({o_err, o_rep_valid, o_ready} !== 3'b001) begin
            errs++;
            $display("FAIL err_one_cycle: got err/valid/ready=%b want 001",
                     {o_err, o_rep_valid, o_ready});
        end
    endtask

    task automatic test_stall();
        send_char("s", 10, 3);
    endtask

    task automatic test_reset_mid();
        i_byte = "q";
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rep_ready = 1'b1;
        @(negedge i_clk);
        i_rep_ready = 1'b0;
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        vec++;
        if ({o_ready, o_rep_valid, o_mod, o_key, o_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            errs++;
            $display("FAIL async_reset: got rdy=%b v=%b mod=%h key=%h err=%b want 1 0 00 00 0",
                     o_ready, o_rep_valid, o_mod, o_key, o_err);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        send_char("z", 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] c;
        for (int i = 0; i < 40; i++) begin
            if (($urandom % 2) == 0) c = 8'($urandom_range(32, 126));
            else c = 8'($urandom);
            send_char(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_modifiers();
        test_back_to_back();
        test_unmapped();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
